// File: rtl/wordlit_resume_engine.sv
// Resumable state-word engine: each accepted step combines the state with LIT and/or in_data; 1-cycle latency.
// Registered valid/ready output; in_ready drops while a result is stalled, halted, or restarting.
module wordlit_resume_engine #(
    parameter int                 IN_W      = 8,
    parameter int                 OUT_W     = 16,
    parameter int                 STATE_W   = 8,
    parameter logic [OUT_W-1:0]   LIT       = 16'h0001,
    parameter logic [STATE_W-1:0] INIT      = 8'hFE,
    parameter int                 MAX_STEPS = 0,
    parameter int                 CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       mode,
    input  logic             restart,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             running,
    output logic [CNT_W-1:0] step_count
);

    logic [STATE_W-1:0] st;
    logic [OUT_W-1:0]   ext;
    logic [OUT_W-1:0]   din;
    logic [OUT_W-1:0]   result;
    logic [CNT_W-1:0]   cnt_next;
    logic               step;
    logic               hit_limit;

    assign in_ready = running && !restart && (!out_valid || out_ready);
    assign step     = in_valid && in_ready;

    always_comb begin
        ext              = '0;
        ext[STATE_W-1:0] = st;
        din              = '0;
        din[IN_W-1:0]    = in_data;
    end

    always_comb begin
        result = '0;
        case (mode)
            2'b00:   result = ext ^ LIT;
            2'b01:   result = ext + LIT;
            2'b10:   result = ext ^ din;
            default: result = (ext + din) ^ LIT;
        endcase
    end

    // Counter saturates; it only halts the engine when a nonzero limit is configured.
    assign cnt_next  = (step_count == {CNT_W{1'b1}}) ? step_count : step_count + 1'b1;
    assign hit_limit = (MAX_STEPS != 0) && (cnt_next == CNT_W'(MAX_STEPS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= INIT;
            out_valid  <= 1'b0;
            out_data   <= '0;
            running    <= 1'b1;
            step_count <= '0;
        end else if (restart) begin
            st         <= INIT;
            out_valid  <= 1'b0;
            running    <= 1'b1;
            step_count <= '0;
        end else if (step) begin
            st         <= result[STATE_W-1:0];
            out_data   <= result;
            out_valid  <= 1'b1;
            step_count <= cnt_next;
            if (hit_limit) begin
                running <= 1'b0;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
